// File: rtl/axis_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_fifo_pkg : shared types and helpers for the AXI-Stream FIFO   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package axis_fifo_pkg;

  typedef enum logic {
    PKT_CUT_THROUGH = 1'b0,
    PKT_STORE_FWD   = 1'b1
  } pkt_mode_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_fifo_ram : simple dual-port storage, sync write, async read   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axis_fifo_ram #(
  parameter int WIDTH  = 37,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/axis_fifo_pkt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_fifo_pkt : FWFT AXI-Stream FIFO with level/packet counters    |
// | and optional store-and-forward gating.                  rev 1.0    |
// +--------------------------------------------------------------------+
module axis_fifo_pkt
  import axis_fifo_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_DATA_DEPTH = 32,
  parameter int PACKET_MODE    = 0,
  parameter int AF_THRESH      = 28,
  parameter int AE_THRESH      = 4
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [AXI_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(AXI_DATA_DEPTH):0] fifo_level,
  output logic                            fifo_empty,
  output logic                            fifo_full,
  output logic                            fifo_afull,
  output logic                            fifo_aempty,
  output logic [$clog2(AXI_DATA_DEPTH):0] pkt_count
);

  localparam int c_ADDR_W    = addr_w(AXI_DATA_DEPTH);
  localparam int c_KEEP_W    = AXI_DATA_WIDTH / 8;
  localparam int c_LVL_W     = c_ADDR_W + 1;
  localparam bit c_STORE_FWD = (PACKET_MODE == int'(PKT_STORE_FWD));

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] tdata;
    logic [c_KEEP_W-1:0]       tkeep;
    logic                      tlast;
  } axis_beat_t;

  logic [c_ADDR_W:0]  r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [c_LVL_W-1:0] r_level, r_pkt_cnt, w_level_nxt, w_pkt_nxt;
  logic               r_empty, r_full, r_afull, r_aempty, r_s_ready, r_lock;
  logic               w_full_nxt, w_empty_nxt, w_wr, w_rd, w_gate;
  logic               w_pkt_in, w_pkt_out;
  axis_beat_t         w_wr_beat, w_rd_beat;

  assign w_wr_beat = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};

  axis_fifo_ram #(
    .WIDTH  ($bits(axis_beat_t)),
    .DEPTH  (AXI_DATA_DEPTH),
    .ADDR_W (c_ADDR_W)
  ) u_ram (
    .clk     (aclk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[c_ADDR_W-1:0]),
    .i_wdata (w_wr_beat),
    .i_raddr (r_rd_ptr[c_ADDR_W-1:0]),
    .o_rdata (w_rd_beat)
  );

  // Store-and-forward: present only complete packets, a full FIFO (oversize
  // packet), or the remainder of a packet whose first beat was already shown.
  assign w_gate        = c_STORE_FWD ? ((r_pkt_cnt != '0) || r_full || r_lock) : 1'b1;
  assign m_axis_tvalid = !r_empty && w_gate && !areset;
  assign s_axis_tready = r_s_ready && !areset;
  assign w_wr          = s_axis_tvalid && s_axis_tready;
  assign w_rd          = m_axis_tvalid && m_axis_tready;
  assign w_pkt_in      = w_wr && s_axis_tlast;
  assign w_pkt_out     = w_rd && w_rd_beat.tlast;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    w_pkt_nxt    = r_pkt_cnt;
    if (w_wr) w_wr_ptr_nxt = r_wr_ptr + (c_ADDR_W+1)'(1);
    if (w_rd) w_rd_ptr_nxt = r_rd_ptr + (c_ADDR_W+1)'(1);
    if (w_wr && !w_rd)      w_level_nxt = r_level + c_LVL_W'(1);
    else if (w_rd && !w_wr) w_level_nxt = r_level - c_LVL_W'(1);
    if (w_pkt_in && !w_pkt_out)      w_pkt_nxt = r_pkt_cnt + c_LVL_W'(1);
    else if (w_pkt_out && !w_pkt_in) w_pkt_nxt = r_pkt_cnt - c_LVL_W'(1);
  end

  assign w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  assign w_full_nxt  = (w_wr_ptr_nxt[c_ADDR_W-1:0] == w_rd_ptr_nxt[c_ADDR_W-1:0]) &&
                       (w_wr_ptr_nxt[c_ADDR_W] != w_rd_ptr_nxt[c_ADDR_W]);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_pkt_cnt <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_s_ready <= 1'b0;
      r_lock    <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_level   <= w_level_nxt;
      r_pkt_cnt <= w_pkt_nxt;
      r_empty   <= w_empty_nxt;
      r_full    <= w_full_nxt;
      r_afull   <= (w_level_nxt >= c_LVL_W'(AF_THRESH));
      r_aempty  <= (w_level_nxt <= c_LVL_W'(AE_THRESH));
      r_s_ready <= !w_full_nxt;
      if (w_pkt_out)          r_lock <= 1'b0;
      else if (m_axis_tvalid) r_lock <= 1'b1;
    end
  end

  assign m_axis_tdata = w_rd_beat.tdata;
  assign m_axis_tkeep = w_rd_beat.tkeep;
  assign m_axis_tlast = w_rd_beat.tlast;
  assign fifo_level   = r_level;
  assign fifo_empty   = r_empty;
  assign fifo_full    = r_full;
  assign fifo_afull   = r_afull;
  assign fifo_aempty  = r_aempty;
  assign pkt_count    = r_pkt_cnt;

endmodule
`default_nettype wire
